// File: rtl/alu_pkg.sv
// Shared ALU op codes, status-flag bit positions and datapath width for the
// ALU and its writeback stage.
package alu_pkg;

  localparam int DATA_W  = 32;
  localparam int NUM_OPS = 5;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_NOT = 3'b100;

  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  function automatic logic is_legal(input logic [2:0] op);
    return op <= OP_NOT;
  endfunction

  // Only arithmetic ops produce meaningful carry/overflow.
  function automatic logic sets_cv(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_wb_fifo.sv
// Generic DEPTH x W synchronous FIFO; head entry is read combinationally.
// Push when full and pop when empty are ignored.
module alu_wb_fifo #(
  parameter  int DEPTH = 2,
  parameter  int W     = 35,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/alu_wb.sv
// ALU writeback/flag stage: buffers results for the register file and keeps
// Z/C/V status plus a sticky illegal-op flag. ALU_WB_PERF_CNT_EN adds op counters.
module alu_wb
  import alu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int RD_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] res,
  input  logic              z,
  input  logic              c,
  input  logic              v,
  input  logic [2:0]        sel,
  input  logic [RD_W-1:0]   rd,
`ifdef ALU_WB_PERF_CNT_EN
  input  logic [2:0]        cnt_sel,
  output logic [15:0]       cnt_out,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_res,
  output logic [RD_W-1:0]   out_rd,
  output logic [2:0]        flags,
  output logic              err
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = DATA_W + RD_W;

  logic              accept, legal, push, pop;
  logic              full, empty;
  logic [CW-1:0]     count;
  logic [EW-1:0]     head;
  logic [DATA_W-1:0] last_res;
  logic [RD_W-1:0]   last_rd;

  assign in_ready  = (count != CW'(DEPTH));
  assign accept    = in_valid && in_ready;
  assign legal     = is_legal(sel);
  assign push      = accept && legal && !full;
  assign out_valid = !empty && !rst;
  assign pop       = out_valid && out_ready;

  alu_wb_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ({res, rd}),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // When drained, the outputs keep showing the last entry handed over.
  assign out_res = empty ? last_res : head[EW-1:RD_W];
  assign out_rd  = empty ? last_rd  : head[RD_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      last_res <= '0;
      last_rd  <= '0;
    end else if (pop) begin
      last_res <= head[EW-1:RD_W];
      last_rd  <= head[RD_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags <= 3'b000;
      err   <= 1'b0;
    end else if (accept) begin
      if (!legal) begin
        err <= 1'b1;
      end else begin
        flags[FLG_Z] <= z;
        if (sets_cv(sel)) begin
          flags[FLG_C] <= c;
          flags[FLG_V] <= v;
        end
      end
    end
  end

`ifdef ALU_WB_PERF_CNT_EN
  logic [NUM_OPS-1:0][15:0] perf;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf <= '0;
    end else if (push) begin
      for (int i = 0; i < NUM_OPS; i++) begin
        if (sel == 3'(i) && perf[i] != 16'hFFFF) perf[i] <= perf[i] + 1'b1;
      end
    end
  end

  always_comb begin
    cnt_out = '0;
    for (int i = 0; i < NUM_OPS; i++) begin
      if (cnt_sel == 3'(i)) cnt_out = perf[i];
    end
  end
`endif

endmodule

// File: doc/alu_wb.md
Name: alu_wb

Overview:
- Writeback/flag stage directly downstream of the combinational ALU (opA/opB/sel -> res/z/c/v).
- Accepts one ALU result per cycle through a valid/ready handshake and buffers it in a small FIFO.
- Presents buffered results to the register-file write port and maintains the architectural Z/C/V status register plus a sticky illegal-op flag.

Parameters:
- DEPTH, 2, FIFO entries; must be a power of two, at least 2.
- RD_W, 3, destination register index width.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous active-high reset
- in_valid  input  1  ALU result valid
- in_ready  output  1  stage can accept a result
- res  input  32  ALU result
- z  input  1  ALU zero flag
- c  input  1  ALU carry flag
- v  input  1  ALU overflow flag
- sel  input  3  ALU op code that produced res
- rd  input  RD_W  destination register index
- out_valid  output  1  writeback entry valid
- out_ready  input  1  register file accepts entry
- out_res  output  32  writeback data
- out_rd  output  RD_W  writeback register index
- flags  output  3  status register {Z,C,V}
- err  output  1  sticky illegal-op flag

Behaviour:
- One clock domain, clk; reset is synchronous and active-high on rst.
- Reset values: in_ready=1, out_valid=0, out_res=0, out_rd=0, flags=3'b000, err=0, FIFO count=0, pointers=0.
- Reset mid-operation discards all buffered entries. No writeback occurs in the reset cycle.
- A push happens when in_valid && in_ready. A pop happens when out_valid && out_ready.
- in_ready = (count != DEPTH). It is derived from registered count, so it has no combinational path from out_ready.
- Full FIFO: in_ready=0; any in_valid is ignored with no side effects.
- Empty FIFO: out_valid=0; out_res/out_rd hold their last values.
- No bypass. Minimum latency is 1 cycle: an entry pushed in cycle N is visible on out_* in cycle N+1.
- Simultaneous push and pop with 0<count<DEPTH: count is unchanged; both pointers advance, wrapping modulo DEPTH.
- Ordering is strict FIFO.
- out_res/out_rd come from the head entry and stay stable while out_valid && !out_ready.
- Flag update happens at push time, regardless of drain:
  - sel 000 (add) or 001 (sub): flags <= {z,c,v}.
  - sel 010 (and), 011 (or), 100 (not): Z <= z; C and V are held.
  - sel 101/110/111 (illegal): the result is accepted (handshake completes) but not enqueued; flags are unchanged; err <= 1.
- err clears only on rst.
- Z is taken from the ALU z input; the stage does not recompute it from res.

Optional Feature:
- Macro ALU_WB_PERF_CNT_EN.
- When defined: five 16-bit saturating counters (add, sub, and, or, not) increment on each legal push of that op. Saturation is at 16'hFFFF.
- Extra ports when defined: cnt_sel input 3 and cnt_out output 16. cnt_out is a combinational read of the counter indexed by cnt_sel; cnt_sel >= 5 reads 0. Counters reset to 0.
- When undefined: no counters and no extra ports; behaviour is otherwise identical.

Decomposition:
- Shared package alu_pkg holds:
  - op-code constants OP_ADD=3'b000, OP_SUB=3'b001, OP_AND=3'b010, OP_OR=3'b011, OP_NOT=3'b100;
  - flag bit indices FLG_Z=2, FLG_C=1, FLG_V=0;
  - the data width constant 32.
- One sub-module: alu_wb_fifo, a generic DEPTH x (32+RD_W) synchronous FIFO with push/pop/full/empty/count.
- Flag, err and counter logic stay in alu_wb.

Test Plan:
- Reset then idle -> in_ready=1, out_valid=0, flags=000, err=0.
- Push add with res=32'h0, z=1, c=1, v=0, rd=3; out_ready=1 -> next cycle out_valid=1, out_res=0, out_rd=3; flags=110 after the push edge.
- Push sub with {z,c,v}=001 setting flags=001, then push and with z=1, c=0, v=0 -> flags=101 (Z updated, C held at 0, V held at 1).
- Hold out_ready=0 and push 3 results with DEPTH=2 -> first two accepted; in_ready=0 after the second push; third held off. Then out_ready=1 drains in order with no loss or duplication.
- Concurrent push and pop at count=1 for 10 cycles -> count stays 1; pointers wrap cleanly; data order preserved.
- Push sel=3'b110 -> in_ready handshake completes, no out_valid, flags unchanged, err=1. Assert rst with 2 entries queued -> out_valid=0, err=0, flags=000 the next cycle.
